// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the phase sequencer and its controller/consumer.
// The master side drives timing and request inputs; the slave is the sequencer.
interface traffic_phase_sequencer_if;
    logic       tick;
    logic       ped_req;
    logic       hold;
    logic       S1;
    logic       S0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       phase_done;
    logic       ped_ack;

    modport master (
        output tick, ped_req, hold,
        input  S1, S0, ns_light, ew_light, phase_done, ped_ack
    );

    modport slave (
        input  tick, ped_req, hold,
        output S1, S0, ns_light, ew_light, phase_done, ped_ack
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Four-phase intersection sequencer: NS green/yellow, EW green/yellow, tick-timed,
// with a latched pedestrian request that ends green early after a minimum time.
module traffic_phase_sequencer #(
    parameter int unsigned G_TIME    = 10,
    parameter int unsigned Y_TIME    = 3,
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    traffic_phase_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        NS_G = 2'b00,
        NS_Y = 2'b01,
        EW_G = 2'b10,
        EW_Y = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(G_TIME - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pend_q, ped_pend_d;
    logic             phase_done_q, phase_done_d;
    logic             ped_ack_q, ped_ack_d;

    logic             counted;
    logic             is_green;
    logic             advance;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ped_pend_d   = ped_pend_q;
        phase_done_d = 1'b0;
        ped_ack_d    = 1'b0;
        ns_light     = 3'b100;
        ew_light     = 3'b100;

        counted  = bus.tick & ~bus.hold;
        is_green = (state_q == NS_G) || (state_q == EW_G);
        // Early end uses the registered request, so a same-cycle ped_req cannot cut this tick.
        advance  = counted &&
                   ((timer_q == (is_green ? G_LAST : Y_LAST)) ||
                    (is_green && ped_pend_q && (timer_q >= MG_LAST)));

        if (advance) begin
            timer_d      = '0;
            phase_done_d = 1'b1;
            case (state_q)
                NS_G:    state_d = NS_Y;
                NS_Y:    state_d = EW_G;
                EW_G:    state_d = EW_Y;
                default: state_d = NS_G;
            endcase
        end else if (counted) begin
            timer_d = timer_q + CNT_W'(1);
        end

        // Entering yellow consumes the request; a new request on that same edge wins.
        if (advance && is_green) begin
            ped_ack_d  = ped_pend_q;
            ped_pend_d = 1'b0;
        end
        if (bus.ped_req) begin
            ped_pend_d = 1'b1;
        end

        case (state_q)
            NS_G:    begin ns_light = 3'b001; ew_light = 3'b100; end
            NS_Y:    begin ns_light = 3'b010; ew_light = 3'b100; end
            EW_G:    begin ns_light = 3'b100; ew_light = 3'b001; end
            default: begin ns_light = 3'b100; ew_light = 3'b010; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= NS_G;
            timer_q      <= '0;
            ped_pend_q   <= 1'b0;
            phase_done_q <= 1'b0;
            ped_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ped_pend_q   <= ped_pend_d;
            phase_done_q <= phase_done_d;
            ped_ack_q    <= ped_ack_d;
        end
    end

    assign bus.S1         = state_q[1];
    assign bus.S0         = state_q[0];
    assign bus.ns_light   = ns_light;
    assign bus.ew_light   = ew_light;
    assign bus.phase_done = phase_done_q;
    assign bus.ped_ack    = ped_ack_q;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer: a behavioural model queues expected
// outputs per cycle, a sampler queues observed outputs, each scenario task compares them.
module tb_traffic_phase_sequencer;
    localparam int G  = 10;
    localparam int Y  = 3;
    localparam int MG = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       pd;
        logic       ack;
    } out_t;

    logic clk;
    logic rst_n;
    traffic_phase_sequencer_if bus ();

    traffic_phase_sequencer #(
        .G_TIME    (G),
        .Y_TIME    (Y),
        .MIN_GREEN (MG),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t exp_q[$];
    out_t obs_q[$];
    bit   cnt_q[$];

    int   errors = 0;
    int   checks = 0;
    out_t e, o;
    bit   c;
    int   ncyc, tk, acks, n_pd;
    int   pd_at[8];

    int   m_ph, m_t;
    bit   m_pend, m_pd, m_ack;

    task automatic model_step(input logic t, input logic p, input logic h, input logic r);
        bit   adv, green;
        int   dur;
        out_t x;
        adv = 0;
        if (!r) begin
            m_ph = 0; m_t = 0; m_pend = 0; m_pd = 0; m_ack = 0;
        end else begin
            green = (m_ph == 0) || (m_ph == 2);
            dur   = green ? G : Y;
            if (t && !h) begin
                if (m_t == dur - 1 || (green && m_pend && m_t >= MG - 1)) adv = 1;
                else m_t++;
            end
            m_pd  = adv;
            m_ack = adv && green && m_pend;
            if (adv) begin
                m_t  = 0;
                m_ph = (m_ph + 1) % 4;
                if (green) m_pend = 0;
            end
            if (p) m_pend = 1;
        end
        x.sel = 2'(m_ph);
        case (m_ph)
            0:       begin x.ns = 3'b001; x.ew = 3'b100; end
            1:       begin x.ns = 3'b010; x.ew = 3'b100; end
            2:       begin x.ns = 3'b100; x.ew = 3'b001; end
            default: begin x.ns = 3'b100; x.ew = 3'b010; end
        endcase
        x.pd  = m_pd;
        x.ack = m_ack;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic t, input logic p, input logic h);
        bus.tick    = t;
        bus.ped_req = p;
        bus.hold    = h;
        model_step(t, p, h, rst_n);
        cnt_q.push_back(t && !h && rst_n);
        @(posedge clk);
        #1;
        obs_q.push_back({bus.S1, bus.S0, bus.ns_light, bus.ew_light, bus.phase_done, bus.ped_ack});
    endtask

    task automatic run_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        ncyc = 0; tk = 0; acks = 0; n_pd = 0;
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.S1, bus.S0, bus.ns_light, bus.ew_light, bus.phase_done, bus.ped_ack} !== 11'b00_001_100_0_0) begin
            errors++;
            $display("FAIL reset_state: got %b want 00_001_100_0_0",
                     {bus.S1, bus.S0, bus.ns_light, bus.ew_light, bus.phase_done, bus.ped_ack});
        end
        run_ticks(24);
        checks++;
        if ({bus.S1, bus.S0} !== 2'b11) begin
            errors++;
            $display("FAIL reset_pre_ew_y: got sel %b want 11", {bus.S1, bus.S0});
        end
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        checks++;
        if ({bus.S1, bus.S0, bus.ns_light, bus.ew_light} !== 8'b00_001_100) begin
            errors++;
            $display("FAIL reset_mid_phase: got %b want 00_001_100", {bus.S1, bus.S0, bus.ns_light, bus.ew_light});
        end
        run_ticks(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 4 || pd_at[0] != 10 || pd_at[1] != 13 || pd_at[2] != 23 || pd_at[3] != 34) begin
            errors++;
            $display("FAIL reset_timing: %0d pulses at %0d %0d %0d %0d, want 10 13 23 34",
                     n_pd, pd_at[0], pd_at[1], pd_at[2], pd_at[3]);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        run_ticks(26);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL free_run cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 4 || pd_at[0] != 10 || pd_at[1] != 13 || pd_at[2] != 23 || pd_at[3] != 26 || acks != 0) begin
            errors++;
            $display("FAIL free_run_timing: %0d pulses at %0d %0d %0d %0d acks %0d, want 10 13 23 26 acks 0",
                     n_pd, pd_at[0], pd_at[1], pd_at[2], pd_at[3], acks);
        end
    endtask

    task automatic test_early_request();
        do_reset();
        run_ticks(1);
        cyc(1'b0, 1'b1, 1'b0);
        run_ticks(18);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL early_req cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 3 || pd_at[0] != 4 || pd_at[1] != 7 || pd_at[2] != 17 || acks != 1) begin
            errors++;
            $display("FAIL early_req_timing: %0d pulses at %0d %0d %0d acks %0d, want 4 7 17 acks 1",
                     n_pd, pd_at[0], pd_at[1], pd_at[2], acks);
        end
    endtask

    task automatic test_late_request();
        do_reset();
        run_ticks(20);
        cyc(1'b0, 1'b1, 1'b0);
        run_ticks(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL late_req cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 3 || pd_at[0] != 10 || pd_at[1] != 13 || pd_at[2] != 21 || acks != 1) begin
            errors++;
            $display("FAIL late_req_timing: %0d pulses at %0d %0d %0d acks %0d, want 10 13 21 acks 1",
                     n_pd, pd_at[0], pd_at[1], pd_at[2], acks);
        end
    endtask

    task automatic test_yellow_request();
        do_reset();
        run_ticks(11);
        cyc(1'b0, 1'b1, 1'b0);
        run_ticks(7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL yellow_req cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 3 || pd_at[0] != 10 || pd_at[1] != 13 || pd_at[2] != 17 || acks != 1) begin
            errors++;
            $display("FAIL yellow_req_timing: %0d pulses at %0d %0d %0d acks %0d, want 10 13 17 acks 1",
                     n_pd, pd_at[0], pd_at[1], pd_at[2], acks);
        end
    endtask

    task automatic test_hold();
        do_reset();
        run_ticks(2);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, (i == 2) ? 1'b1 : 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if ({bus.S1, bus.S0, bus.phase_done} !== 3'b000) begin
            errors++;
            $display("FAIL hold_frozen: got sel/pd %b want 000", {bus.S1, bus.S0, bus.phase_done});
        end
        run_ticks(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL hold cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 1 || pd_at[0] != 4 || acks != 1) begin
            errors++;
            $display("FAIL hold_timing: %0d pulses first at %0d acks %0d, want 1 at 4 acks 1", n_pd, pd_at[0], acks);
        end
    endtask

    task automatic test_coincident_request();
        do_reset();
        run_ticks(1);
        cyc(1'b0, 1'b1, 1'b0);
        run_ticks(2);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        run_ticks(7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL coincident cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 3 || pd_at[0] != 4 || pd_at[1] != 7 || pd_at[2] != 11 || acks != 2) begin
            errors++;
            $display("FAIL coincident_timing: %0d pulses at %0d %0d %0d acks %0d, want 4 7 11 acks 2",
                     n_pd, pd_at[0], pd_at[1], pd_at[2], acks);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 26; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = cnt_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL back_to_back cycle %0d: got %b want %b", ncyc, o, e); end
            if (c) tk++;
            if (o.pd) begin if (n_pd < 8) pd_at[n_pd] = tk; n_pd++; end
            if (o.ack) acks++;
            ncyc++;
        end
        checks++;
        if (n_pd != 4 || pd_at[0] != 10 || pd_at[1] != 13 || pd_at[2] != 23 || pd_at[3] != 26 || {bus.S1, bus.S0} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_back_timing: %0d pulses at %0d %0d %0d %0d sel %b, want 10 13 23 26 sel 00",
                     n_pd, pd_at[0], pd_at[1], pd_at[2], pd_at[3], {bus.S1, bus.S0});
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        bus.hold    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_early_request();
        test_late_request();
        test_yellow_request();
        test_hold();
        test_coincident_request();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Timed four-phase sequencer for the intersection controller. Steps through NS-green, NS-yellow, EW-green and EW-yellow. Drives the 2-bit select pair S1/S0 consumed by the downstream 4-to-1 phase mux, plus decoded NS/EW lamp outputs. Phase timing is counted in ticks from an external enable pulse. A latched pedestrian request cuts the current green short once its minimum green time has elapsed.

Parameters:
G_TIME, 10, green duration in ticks (must be >= MIN_GREEN)
Y_TIME, 3, yellow duration in ticks (must be >= 1)
MIN_GREEN, 4, minimum green ticks before a pedestrian request may end green (must be >= 1)
CNT_W, 8, phase timer width; 2^CNT_W must be > max(G_TIME, Y_TIME)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
tick  in  1  one-cycle timing enable pulse (e.g. 1 Hz strobe)
ped_req  in  1  pedestrian crossing request, level or pulse
hold  in  1  freeze: while high, ticks are ignored
S1  out  1  phase select MSB to downstream mux
S0  out  1  phase select LSB to downstream mux
ns_light  out  3  NS lamps {R,Y,G}
ew_light  out  3  EW lamps {R,Y,G}
phase_done  out  1  one-cycle pulse coincident with the first cycle of a new phase
ped_ack  out  1  one-cycle pulse when a pending request is consumed

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=NS_G, timer=0, ped_pend=0, phase_done=0, ped_ack=0.
  - Hence S1S0=00, ns_light=001, ew_light=100.
  - Reset overrides all inputs and applies mid-phase.
- State encoding drives {S1,S0} directly from the state register, with no extra latency: NS_G=00, NS_Y=01, EW_G=10, EW_Y=11.
- Lamp decode (combinational from state):
  - NS_G: ns=001, ew=100
  - NS_Y: ns=010, ew=100
  - EW_G: ns=100, ew=001
  - EW_Y: ns=100, ew=010
  - Both directions are never non-red at once.
- Transition order: NS_G -> NS_Y -> EW_G -> EW_Y -> NS_G. No other transitions exist.
- Timer: counts only on cycles with tick=1 and hold=0. Let dur = G_TIME for green states, Y_TIME for yellow states.
  - On a counted tick with timer==dur-1: advance state, timer <= 0.
  - Otherwise on a counted tick: timer <= timer+1.
  - Each phase therefore lasts exactly dur counted ticks. Full cycle with no requests = 2*(G_TIME+Y_TIME) ticks.
- Early green end: in NS_G or EW_G, a counted tick with ped_pend==1 and timer >= MIN_GREEN-1 advances to the following yellow, timer <= 0.
- ped_pend:
  - Set on any cycle with ped_req=1, in any state, including during hold.
  - Cleared on the edge that enters NS_Y or EW_Y. ped_ack pulses in the cycle after that edge, but only if ped_pend was 1 before the edge.
  - If ped_req=1 on the clearing edge, set wins and ped_pend stays 1, so it applies to the next green.
  - The decision uses the registered ped_pend. A ped_req arriving in the same cycle as a tick does not affect that tick.
- Yellow is never shortened. A request made during yellow carries into the next green.
- phase_done: registered, high for exactly one cycle after every state advance; otherwise 0.
- hold: timer and state frozen. ped_pend still latches. Releasing hold resumes from the frozen timer value.
- tick held high for multiple cycles: each high cycle counts as one tick.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with tick, ped_req and hold toggling -> S1S0=00, ns=001, ew=100, phase_done=0, ped_ack=0. Reset asserted mid-EW_Y -> next cycle NS_G, timer restarts (10 ticks to NS_Y).
- Free run with defaults, no requests:
  - S1S0 sequence 00(10 ticks), 01(3), 10(10), 11(3), back to 00 after 26 ticks.
  - phase_done pulses exactly 4 times per cycle.
  - Lamps match the decode table every cycle.
- Early request: ped_req pulse after tick 1 of NS_G -> NS_Y entered on the 4th counted tick; ped_ack pulses once; EW_G then lasts the full 10 ticks.
- Late request: ped_req after tick 7 of EW_G -> EW_Y entered on the next counted tick (8th); ped_ack pulses once.
- Request during NS_Y -> NS_Y still lasts 3 ticks. Following EW_G ends at its 4th tick.
- Boundary cases:
  - hold=1 for 5 ticks in the middle of NS_G -> S1S0 and timer unchanged; ped_req during hold is latched and honoured at the first eligible tick after release.
  - ped_req coincident with the yellow-entry edge -> ped_pend remains 1 and shortens the next green.
